// File: rtl/fc_tree_flow_ctrl_if.sv
// Handshake bundle between the FC adder-tree flow controller and its
// neighbours.
//   s_valid / s_ready : product vector from the multiplier array into the tree
//   m_valid / m_ready : tree result toward the downstream consumer
//   m_data            : tree result word
// Modports:
//   master : the controller (drives s_ready, m_valid, m_data)
//   slave  : the surrounding logic (drives s_valid, m_ready)
interface fc_tree_flow_ctrl_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  s_valid;
  logic                  s_ready;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;

  modport master (
    input  s_valid, m_ready,
    output s_ready, m_valid, m_data
  );

  modport slave (
    output s_valid, m_ready,
    input  s_ready, m_valid, m_data
  );
endinterface

// File: rtl/fc_tree_flow_ctrl.sv
// Flow controller for the FC-layer adder-tree pipeline (32-lane FP32
// reduction, bias add, ReLU, 7 register stages). It accepts one product
// vector per neuron, produces the per-stage load enables with full
// backpressure, forwards the tree result downstream, counts neurons per
// layer pass and pulses done when the last result is accepted.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   start             one-cycle pulse, begins a pass (ignored while busy)
//   num_neurons       vectors in this pass, latched on start
//   bus (master)      s_valid/s_ready in, m_valid/m_ready/m_data out
//   valid_in_bias     load enable for tree stage 1 (reg1)
//   valid_pipeline    load enables for stages 2..7 (bit 0 = reg2, bit 5 = o_data)
//   tree_o_data       tree o_data, passed straight to m_data
//   busy              pass in progress (RUN or DONE)
//   done              one-cycle pulse after the last result is accepted
//
// Optional build macro FC_TREE_PERF_CNT_EN adds stall_cycles and
// bubble_cycles counters (cleared on start, counted in RUN).
module fc_tree_flow_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_W      = 12,
  parameter int N_STAGES   = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [CNT_W-1:0]      num_neurons,
  fc_tree_flow_ctrl_if.master   bus,
  output logic                  valid_in_bias,
  output logic [5:0]            valid_pipeline,
  input  logic [DATA_WIDTH-1:0] tree_o_data,
  output logic                  busy,
  output logic                  done
`ifdef FC_TREE_PERF_CNT_EN
  ,
  output logic [31:0]           stall_cycles,
  output logic [31:0]           bubble_cycles
`endif
);

  localparam int unsigned LAST = N_STAGES - 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     num_q, num_d;
  logic [CNT_W-1:0]     issued_q, issued_d;
  logic [CNT_W-1:0]     out_q, out_d;
  logic [N_STAGES-1:0]  v_q, v_d;
  logic [N_STAGES-1:0]  rdy, en, adv;
  logic                 issue_ok;
  logic                 s_ready;
  logic                 r;

  // Stage-valid pipeline. rdy[k] = ~v[k] | adv[k] reduces to ~v[k] | rdy[k+1]
  // because adv[k] = en[k+1] = v[k] & rdy[k+1]; building it with a scalar
  // running term keeps the ready chain acyclic and free of s_valid.
  always_comb begin
    issue_ok = (state_q == RUN) && (issued_q < num_q);

    rdy       = '0;
    r         = ~v_q[LAST] | bus.m_ready;
    rdy[LAST] = r;
    for (int unsigned i = 0; i < LAST; i++) begin
      r                = ~v_q[LAST-1-i] | r;
      rdy[LAST-1-i]    = r;
    end

    en    = '0;
    en[0] = bus.s_valid & issue_ok & rdy[0];
    for (int unsigned k = 1; k <= LAST; k++) begin
      en[k] = v_q[k-1] & rdy[k];
    end

    adv       = '0;
    adv[LAST] = bus.m_ready;
    for (int unsigned k = 0; k < LAST; k++) begin
      adv[k] = en[k+1];
    end

    v_d     = en | (v_q & ~adv);
    s_ready = issue_ok & rdy[0];
  end

  always_comb begin
    state_d  = state_q;
    num_d    = num_q;
    issued_d = issued_q;
    out_d    = out_q;

    if (bus.s_valid && s_ready)
      issued_d = issued_q + 1'b1;
    if (v_q[LAST] && bus.m_ready)
      out_d = out_q + 1'b1;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = RUN;
          num_d    = num_neurons;
          issued_d = '0;
          out_d    = '0;
        end
      end
      RUN:  if (out_q == num_q) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      num_q    <= '0;
      issued_q <= '0;
      out_q    <= '0;
      v_q      <= '0;
    end else begin
      state_q  <= state_d;
      num_q    <= num_d;
      issued_q <= issued_d;
      out_q    <= out_d;
      v_q      <= v_d;
    end
  end

`ifdef FC_TREE_PERF_CNT_EN
  logic [31:0] stall_q, bubble_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q  <= '0;
      bubble_q <= '0;
    end else if (state_q == IDLE && start) begin
      stall_q  <= '0;
      bubble_q <= '0;
    end else if (state_q == RUN) begin
      stall_q  <= stall_q  + 32'(v_q[LAST] & ~bus.m_ready);
      bubble_q <= bubble_q + 32'(issue_ok & ~bus.s_valid);
    end
  end

  assign stall_cycles  = stall_q;
  assign bubble_cycles = bubble_q;
`endif

  assign bus.s_ready    = s_ready;
  assign bus.m_valid    = v_q[LAST];
  assign bus.m_data     = tree_o_data;
  assign valid_in_bias  = en[0];
  assign valid_pipeline = en[LAST:1];
  assign busy           = (state_q != IDLE);
  assign done           = (state_q == DONE);

endmodule

// File: tb/tb_fc_tree_flow_ctrl.sv
// Directed bench for fc_tree_flow_ctrl. A small model of the 7-stage adder
// tree is loaded by the controller's enables; accepted vector tags are
// queued with their accept cycle and popped when results are accepted.
module tb_fc_tree_flow_ctrl;

  localparam logic [31:0] BIAS = 32'hA5A5_0000;

  logic        clk;
  logic        rst;
  logic        start;
  logic [11:0] num_neurons;
  logic        valid_in_bias;
  logic [5:0]  valid_pipeline;
  logic [31:0] tree_o_data;
  logic        busy;
  logic        done;

  fc_tree_flow_ctrl_if #(.DATA_WIDTH(32)) bus ();

  fc_tree_flow_ctrl #(
    .DATA_WIDTH(32),
    .CNT_W     (12),
    .N_STAGES  (7)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .num_neurons   (num_neurons),
    .bus           (bus),
    .valid_in_bias (valid_in_bias),
    .valid_pipeline(valid_pipeline),
    .tree_o_data   (tree_o_data),
    .busy          (busy),
    .done          (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Tree model: each stage loads only when its enable is high.
  logic [31:0] in_tag;
  logic [31:0] st [7];
  always_ff @(posedge clk) begin
    if (valid_in_bias) st[0] <= in_tag ^ BIAS;
    for (int k = 1; k < 7; k++)
      if (valid_pipeline[k-1]) st[k] <= st[k-1];
  end
  assign tree_o_data = st[6];

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  int vectors, errs;
  int n_acc, n_res, mv_cnt, sr_cnt, first_acc, first_mv, last_res;
  int done_cyc, done_cnt, vib_cnt, vib_first, vib_last, vp5_bad;
  int acc_at_hold, sr_at_hold, busy_at1;
  int vp_cnt[6];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One layer pass. hold: m_ready low for cycles < hold. tog: s_valid on odd
  // cycles only. restart_at: extra start pulse (num_neurons=9) at that cycle.
  // abort_at: assert rst at that cycle and end the pass.
  task automatic run_pass(input int n, input int hold, input bit tog,
                          input int restart_at, input int abort_at, input int bound);
    int  cyc;
    bit  acc;
    exp_t e;
    n_acc = 0; n_res = 0; mv_cnt = 0; sr_cnt = 0; first_acc = -1; first_mv = -1;
    last_res = -1; done_cyc = -1; done_cnt = 0; vib_cnt = 0; vib_first = -1;
    vib_last = -1; vp5_bad = 0; acc_at_hold = -1; sr_at_hold = -1; busy_at1 = -1;
    for (int j = 0; j < 6; j++) vp_cnt[j] = 0;
    sb.delete();
    cyc = 0;
    while (1) begin
      start       = (cyc == 0) || (cyc == restart_at);
      num_neurons = (cyc == restart_at) ? 12'd9 : 12'(n);
      bus.m_ready = (cyc >= hold);
      bus.s_valid = tog ? ((cyc % 2) == 1) : 1'b1;
      if (cyc == abort_at) begin
        rst = 1'b1;
        #1;
        check("rst_s_ready", bus.s_ready, 0);
        check("rst_vib", valid_in_bias, 0);
        check("rst_vp", valid_pipeline, 0);
        check("rst_m_valid", bus.m_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        @(negedge clk);
        rst = 1'b0; start = 1'b0; bus.s_valid = 1'b0;
        sb.delete();
        @(negedge clk);
        return;
      end
      #1;
      acc = bus.s_valid && bus.s_ready;
      if (acc) begin
        e.data = in_tag ^ BIAS; e.cyc = cyc;
        sb.push_back(e);
        if (first_acc < 0) first_acc = cyc;
        n_acc++;
      end
      if (bus.s_ready) sr_cnt++;
      if (cyc == 1) busy_at1 = busy;
      if (bus.m_valid) begin
        mv_cnt++;
        if (first_mv < 0) first_mv = cyc;
        if (bus.m_ready) begin
          if (sb.size() == 0) check("extra_result", 1, 0);
          else begin
            e = sb.pop_front();
            check("m_data", bus.m_data, e.data);
            if (hold == 0) check("latency", cyc - e.cyc, 7);
          end
          n_res++;
          last_res = cyc;
        end else if (valid_pipeline[5]) vp5_bad++;
      end
      if (valid_in_bias) begin
        vib_cnt++;
        if (vib_first < 0) vib_first = cyc;
        vib_last = cyc;
      end
      for (int j = 0; j < 6; j++) if (valid_pipeline[j]) vp_cnt[j]++;
      if (hold > 0 && cyc == hold - 1) begin
        acc_at_hold = n_acc;
        sr_at_hold  = bus.s_ready;
      end
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      @(negedge clk);
      if (acc) in_tag++;
      if ((done_cyc >= 0 && cyc >= done_cyc + 2) || cyc >= bound) break;
      cyc++;
    end
    start = 1'b0;
    bus.s_valid = 1'b0;
    check("done_seen", done_cyc >= 0, 1);
    check("done_width", done_cnt, 1);
    check("sb_empty", sb.size(), 0);
  endtask

  initial begin
    vectors = 0; errs = 0;
    rst = 1'b1; start = 1'b0; num_neurons = '0; in_tag = 32'd100;
    bus.s_valid = 1'b0; bus.m_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("reset_s_ready", bus.s_ready, 0);
    check("reset_vib", valid_in_bias, 0);
    check("reset_vp", valid_pipeline, 0);
    check("reset_m_valid", bus.m_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Full throughput, 4 neurons.
    run_pass(4, 0, 1'b0, -1, -1, 100);
    check("A_accepts", n_acc, 4);
    check("A_s_ready_cycles", sr_cnt, 4);
    check("A_vib_count", vib_cnt, 4);
    check("A_vib_consecutive", vib_last - vib_first, 3);
    check("A_first_latency", first_mv - first_acc, 7);
    check("A_results", n_res, 4);
    check("A_mvalid_cycles", mv_cnt, 4);
    check("A_busy", busy_at1, 1);
    check("A_done_after_last", done_cyc - last_res, 2);

    // Stall with fewer vectors than stages.
    run_pass(3, 20, 1'b0, -1, -1, 100);
    check("B_results", n_res, 3);
    for (int j = 0; j < 6; j++) check("B_vp_count", vp_cnt[j], 3);
    check("B_vib_count", vib_cnt, 3);
    check("B_vp5_hold", vp5_bad, 0);

    // Stall with more vectors than stages.
    run_pass(10, 12, 1'b0, -1, -1, 100);
    check("C_accepts_at_stall", acc_at_hold, 7);
    check("C_s_ready_at_stall", sr_at_hold, 0);
    check("C_vp5_hold", vp5_bad, 0);
    check("C_accepts", n_acc, 10);
    check("C_results", n_res, 10);

    // Gapped input.
    run_pass(5, 0, 1'b1, -1, -1, 100);
    check("D_accepts", n_acc, 5);
    check("D_results", n_res, 5);
    check("D_mvalid_cycles", mv_cnt, 5);

    // Empty pass.
    run_pass(0, 0, 1'b0, -1, -1, 40);
    check("E_done_cycle", done_cyc, 2);
    check("E_accepts", n_acc, 0);
    check("E_s_ready_cycles", sr_cnt, 0);
    check("E_vib_count", vib_cnt, 0);

    // Start while busy is ignored.
    run_pass(2, 0, 1'b0, 3, -1, 100);
    check("F_accepts", n_acc, 2);
    check("F_results", n_res, 2);

    // Reset with 4 results in flight, then a clean pass.
    run_pass(8, 100, 1'b0, -1, 5, 100);
    check("G_inflight_before_rst", n_acc, 4);
    run_pass(2, 0, 1'b0, -1, -1, 100);
    check("G_accepts", n_acc, 2);
    check("G_results", n_res, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
